rom_port_arbiter: RTL
=====================

Name: rom_port_arbiter

Overview:
- Shares one synchronous read port of the 512x32 boot ROM between two requesters: requester 0 (CPU data-side loads) and requester 1 (debug/programmer reader).
- Converts byte addresses to word addresses, arbitrates round-robin and sequences the ROM's one-cycle registered read.
- Returns the data with a one-cycle valid pulse. Sits between the bus decoder and the ROM's port B (enable, address, data out).

Parameters:
- ADDR_W, 9, ROM word-address width (512 words).
- DATA_W, 32, ROM data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 read request, level, held until valid0
- addr0  in  32  requester 0 byte address
- valid0  out  1  one-cycle pulse: rdata0/err0 valid
- rdata0  out  DATA_W  read data for requester 0
- err0  out  1  misaligned address, qualified by valid0
- req1, addr1, valid1, rdata1, err1: same as requester 0, for requester 1
- rom_en  out  1  ROM port enable
- rom_addr  out  ADDR_W  ROM word address = byte_addr[ADDR_W+1:2]; higher bits ignored (alias)
- rom_do  in  DATA_W  ROM registered data out

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie. Reset mid-transaction discards the pending read and emits no valid. A req still high after reset release is re-arbitrated from IDLE.
- All outputs are registered.
- FSM states: IDLE, READ, RESP, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the requester that is not last_grant.
  - On grant: latch owner, update last_grant.
  - Aligned address (bits [1:0] = 0): rom_en<=1, rom_addr<=addr[ADDR_W+1:2], go to READ.
  - Misaligned address: no ROM access, set pending err, go to RESP.
- READ: rom_en<=0 (exactly one enable cycle; the ROM captures on this edge); go to RESP.
- RESP:
  - Owner's rdata<=rom_do (0 if err), err<=pending err, valid pulses for one cycle; the other requester's outputs are unchanged.
  - Go to DONE.
- DONE: one dead cycle; req inputs ignored. Requesters drop req in the cycle valid is high. Go to IDLE.
- rdata/err hold their value until the next response to the same requester.
- Valid timing: req sampled at edge E0 -> valid high after edge E2 (3-cycle latency for aligned reads, 2 cycles for misaligned).
- Back-to-back throughput: one transaction per 4 cycles.
- Fairness: with both reqs continuously held, grants alternate 0,1,0,1.
- A req dropped before grant is ignored. A req dropped after grant is still completed and its valid still pulses.
- A requester never sees valid without having held req at its grant.

Decomposition:
- Package plp_rom_pkg:
  - ROM_WORDS=512, ROM_ADDR_W=9, ROM_DATA_W=32
  - state enum {IDLE, READ, RESP, DONE}
  - byte_to_word(addr) function
- Sub-module rr_arb2: 2-way round-robin picker; inputs req[1:0], last; output gnt one-hot; combinational.

Test Plan:
- Bench ROM model preloads word0=32'h08000063, word21=32'h3c08f060.
- req0, addr0=0x00000000 -> rom_en high exactly one cycle with rom_addr=0; valid0 three cycles after the req edge; rdata0=32'h08000063; err0=0.
- req1, addr1=0x00000054 -> rom_addr=21; valid1 pulse; rdata1=32'h3c08f060; valid0 stays 0.
- req0 and req1 both asserted from reset, each dropped after its valid then re-raised -> service order 0,1,0,1; no double grant.
- req0, addr0=0x00000006 -> rom_en never asserted; valid0 after 2 cycles; err0=1; rdata0=0.
- addr1=0x00000800 -> aliases to rom_addr=0; rdata1=32'h08000063.
- rst asserted for one cycle while state=READ -> no valid pulse; all outputs 0. With req0 still high, the read restarts and completes normally.

Source files
------------

// File: rtl/plp_rom_pkg.sv
// Shared types and constants for the boot-ROM read-port arbiter.
package plp_rom_pkg;

  localparam int ROM_WORDS  = 512;
  localparam int ROM_ADDR_W = 9;
  localparam int ROM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  // Byte address to ROM word address; bits above the ROM range alias.
  function automatic logic [ROM_ADDR_W-1:0] byte_to_word(input logic [31:0] addr);
    return addr[ROM_ADDR_W+1:2];
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant; a lone request always wins, a tie goes away from last_i.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the boot ROM's synchronous read port between two requesters.
// Each transaction: grant in IDLE, one ROM enable cycle, registered response,
// then a dead cycle so requesters can drop req before the next arbitration.
module rom_port_arbiter
  import plp_rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [31:0]       addr0,
  output logic              valid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic [31:0]       addr1,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_do
);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                perr_q, perr_d;
  logic                rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                valid0_q, valid0_d, valid1_q, valid1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]          gnt;
  logic [31:0]         gaddr;
  logic                aligned;
  logic                unused_hi;

  rr_arb2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign gaddr     = gnt[1] ? addr1 : addr0;
  assign aligned   = (gaddr[1:0] == 2'b00);
  assign unused_hi = ^gaddr[31:ADDR_W+2];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: misaligned grants skip the ROM access and respond directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|gnt) state_d = aligned ? READ : RESP;
      READ: state_d = RESP;
      RESP: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; response registers hold unless this is their owner's RESP.
  always_comb begin
    last_d     = last_q;
    owner_d    = owner_q;
    perr_d     = perr_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          perr_d  = ~aligned;
          if (aligned) begin
            rom_en_d   = 1'b1;
            rom_addr_d = gaddr[ADDR_W+1:2];
          end
        end
      end
      RESP: begin
        if (owner_q) begin
          valid1_d = 1'b1;
          rdata1_d = perr_q ? '0 : rom_do;
          err1_d   = perr_q;
        end else begin
          valid0_d = 1'b1;
          rdata0_d = perr_q ? '0 : rom_do;
          err0_d   = perr_q;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and transaction context; last grant resets to 1 so requester 0 wins first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      perr_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      last_q     <= last_d;
      owner_q    <= owner_d;
      perr_q     <= perr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign valid0   = valid0_q;
  assign valid1   = valid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;

endmodule
